// File: rtl/echo_delay.sv
// echo_delay: feedback echo stage. Each accepted sample reads one tap from a
// circular delay buffer, stores x + fb*tap back into the buffer and emits
// x + mix*tap. One sample in flight: IDLE -> READ -> CALC -> WRITE -> IDLE.
// Optional feature macro: ECHO_CLEAR_EN (zero the whole buffer after every reset).
module echo_delay #(
  parameter int fxp_size  = 16,
  parameter int addr_bits = 12,
  parameter int coef_bits = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [fxp_size-1:0]  i_sample,
  input  logic [addr_bits-1:0] i_par_delay,
  input  logic [coef_bits-1:0] i_par_feedback,
  input  logic [coef_bits-1:0] i_par_mix,
  output logic                 o_ready,
  output logic [fxp_size-1:0]  o_sample,
  output logic                 o_valid
);

  localparam int depth     = 2 ** addr_bits;
  localparam int prod_bits = fxp_size + coef_bits + 1;
  localparam int sum_bits  = fxp_size + 2;

  localparam logic [addr_bits-1:0] addr_zero = {addr_bits{1'b0}};
  localparam logic [addr_bits-1:0] addr_one  = {{(addr_bits-1){1'b0}}, 1'b1};
  localparam logic [addr_bits-1:0] addr_max  = {addr_bits{1'b1}};
  localparam logic [fxp_size-1:0]  fxp_zero  = {fxp_size{1'b0}};
  localparam logic [coef_bits-1:0] coef_zero = {coef_bits{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  // Clamp a widened sum into the signed sample range.
  function automatic logic [fxp_size-1:0] sat_fxp(input logic [sum_bits-1:0] v);
    logic [fxp_size-1:0] r;
    if (v[sum_bits-1:fxp_size-1] == {(sum_bits-fxp_size+1){v[sum_bits-1]}}) begin
      r = v[fxp_size-1:0];
    end else if (v[sum_bits-1]) begin
      r = {1'b1, {(fxp_size-1){1'b0}}};
    end else begin
      r = {1'b0, {(fxp_size-1){1'b1}}};
    end
    return r;
  endfunction

  // Signed tap times unsigned Q0 gain, arithmetically shifted back to sample scale.
  function automatic logic [fxp_size:0] scale_tap(input logic [fxp_size-1:0] d,
                                                  input logic [coef_bits-1:0] g);
    logic signed [prod_bits-1:0] d_ext;
    logic signed [prod_bits-1:0] g_ext;
    logic signed [prod_bits-1:0] prod;
    d_ext = {{(coef_bits+1){d[fxp_size-1]}}, d};
    g_ext = {{(fxp_size+1){1'b0}}, g};
    prod  = d_ext * g_ext;
    return (fxp_size+1)'(prod >>> coef_bits);
  endfunction

  state_t               state_q, state_d;
  logic [addr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic                 wrapped_q, wrapped_d;
  logic [fxp_size-1:0]  x_q, x_d;
  logic [addr_bits-1:0] delay_q, delay_d;
  logic [coef_bits-1:0] fb_q, fb_d;
  logic [coef_bits-1:0] mix_q, mix_d;
  logic [addr_bits-1:0] rd_addr_q, rd_addr_d;
  logic [fxp_size-1:0]  fbk_q, fbk_d;
  logic [fxp_size-1:0]  o_sample_q, o_sample_d;
  logic                 o_valid_q, o_valid_d;
  logic                 o_ready_q, o_ready_d;
  logic [fxp_size-1:0]  rd_data_q;
`ifdef ECHO_CLEAR_EN
  logic [addr_bits-1:0] clr_addr_q, clr_addr_d;
`endif

  logic                 mem_we;
  logic [addr_bits-1:0] mem_waddr;
  logic [fxp_size-1:0]  mem_wdata;
  logic [addr_bits-1:0] delay_eff;
  logic [fxp_size-1:0]  tap;
  logic [fxp_size:0]    fb_term;
  logic [fxp_size:0]    mix_term;
  logic [sum_bits-1:0]  fbk_sum;
  logic [sum_bits-1:0]  wet_sum;

  logic [fxp_size-1:0]  mem [depth];

  // Next-state, datapath and buffer-write control for the sample sequencer.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wrapped_d  = wrapped_q;
    x_d        = x_q;
    delay_d    = delay_q;
    fb_d       = fb_q;
    mix_d      = mix_q;
    rd_addr_d  = rd_addr_q;
    fbk_d      = fbk_q;
    o_sample_d = o_sample_q;
    o_valid_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = fbk_q;
    tap        = fxp_zero;
    fb_term    = {(fxp_size+1){1'b0}};
    mix_term   = {(fxp_size+1){1'b0}};
    fbk_sum    = {sum_bits{1'b0}};
    wet_sum    = {sum_bits{1'b0}};
`ifdef ECHO_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    // A zero delay would read the slot about to be written; treat it as one.
    if (i_par_delay == addr_zero) begin
      delay_eff = addr_one;
    end else begin
      delay_eff = i_par_delay;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          x_d       = i_sample;
          delay_d   = delay_eff;
          fb_d      = i_par_feedback;
          mix_d     = i_par_mix;
          rd_addr_d = wr_ptr_q - delay_eff;
          state_d   = ST_READ;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // Slots never written since reset hold stale data and must read as silence.
        if (wrapped_q || (delay_q <= wr_ptr_q)) begin
          tap = rd_data_q;
        end else begin
          tap = fxp_zero;
        end
        fb_term    = scale_tap(tap, fb_q);
        mix_term   = scale_tap(tap, mix_q);
        fbk_sum    = {{2{x_q[fxp_size-1]}}, x_q} + {fb_term[fxp_size], fb_term};
        wet_sum    = {{2{x_q[fxp_size-1]}}, x_q} + {mix_term[fxp_size], mix_term};
        fbk_d      = sat_fxp(fbk_sum);
        o_sample_d = sat_fxp(wet_sum);
        o_valid_d  = 1'b1;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr_q;
        mem_wdata = fbk_q;
        wr_ptr_d  = wr_ptr_q + addr_one;
        if (wr_ptr_q == addr_max) begin
          wrapped_d = 1'b1;
        end else begin
          wrapped_d = wrapped_q;
        end
        state_d   = ST_IDLE;
      end
`ifdef ECHO_CLEAR_EN
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = fxp_zero;
        if (clr_addr_q == addr_max) begin
          clr_addr_d = addr_zero;
          state_d    = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + addr_one;
          state_d    = ST_CLEAR;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    o_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef ECHO_CLEAR_EN
      state_q    <= ST_CLEAR;
      clr_addr_q <= addr_zero;
      o_ready_q  <= 1'b0;
`else
      state_q    <= ST_IDLE;
      o_ready_q  <= 1'b1;
`endif
      wr_ptr_q   <= addr_zero;
      wrapped_q  <= 1'b0;
      x_q        <= fxp_zero;
      delay_q    <= addr_one;
      fb_q       <= coef_zero;
      mix_q      <= coef_zero;
      rd_addr_q  <= addr_zero;
      fbk_q      <= fxp_zero;
      o_sample_q <= fxp_zero;
      o_valid_q  <= 1'b0;
    end else begin
`ifdef ECHO_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
      state_q    <= state_d;
      o_ready_q  <= o_ready_d;
      wr_ptr_q   <= wr_ptr_d;
      wrapped_q  <= wrapped_d;
      x_q        <= x_d;
      delay_q    <= delay_d;
      fb_q       <= fb_d;
      mix_q      <= mix_d;
      rd_addr_q  <= rd_addr_d;
      fbk_q      <= fbk_d;
      o_sample_q <= o_sample_d;
      o_valid_q  <= o_valid_d;
    end
  end

  // Delay buffer: synchronous read in READ, write gated off while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem[rd_addr_q];
  end

  assign o_ready  = o_ready_q;
  assign o_sample = o_sample_q;
  assign o_valid  = o_valid_q;

endmodule

// File: tb/tb_echo_delay.sv
// Self-checking bench for echo_delay: table vectors, hand-written timing
// sequences and a long wrap-around run, all scored through an expected queue.
`timescale 1ns/1ps
module tb_echo_delay;

  localparam int depth = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_sample = 16'd0;
  logic [11:0] i_par_delay = 12'd0;
  logic [7:0]  i_par_feedback = 8'd0;
  logic [7:0]  i_par_mix = 8'd0;
  logic        o_ready;
  logic [15:0] o_sample;
  logic        o_valid;

  always #5 clk = ~clk;

  echo_delay dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample),
    .i_par_delay(i_par_delay), .i_par_feedback(i_par_feedback),
    .i_par_mix(i_par_mix), .o_ready(o_ready), .o_sample(o_sample),
    .o_valid(o_valid)
  );

  typedef struct {
    int sample; int delay; int fb; int mix; int exp_out; bit rst_before;
  } vec_t;

  vec_t vecs [0:15];
  int   exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int   m_mem [depth];
  int   m_wr = 0;
  bit   m_wrapped = 1'b0;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  function automatic int model_step(input int x, input int d, input int fb, input int mix);
    int dl, addr, tp, fbk, wet;
    dl   = (d == 0) ? 1 : d;
    addr = (m_wr - dl + depth) % depth;
    tp   = (m_wrapped || dl <= m_wr) ? m_mem[addr] : 0;
    fbk  = sat16(x + ((tp * fb) >>> 8));
    wet  = sat16(x + ((tp * mix) >>> 8));
    m_mem[m_wr] = fbk;
    if (m_wr == depth - 1) m_wrapped = 1'b1;
    m_wr = (m_wr + 1) % depth;
    return wet;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Scoreboard: every output strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got o_sample=%0d, expected no output",
                 int'($signed(o_sample)));
      end else begin
        check("o_sample", int'($signed(o_sample)), exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input int limit);
    int cnt;
    cnt = 0;
    while (!o_ready && cnt < limit) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!o_ready) check("ready_timeout", int'(o_ready), 1);
  endtask

  task automatic drive(input int s, input int d, input int fb, input int mix, input int want);
    wait_ready(10000);
    exp_q.push_back(want);
    i_valid        = 1'b1;
    i_sample       = 16'(s);
    i_par_delay    = 12'(d);
    i_par_feedback = 8'(fb);
    i_par_mix      = 8'(mix);
    @(posedge clk); #1;
    i_valid        = 1'b0;
    i_sample       = 16'($urandom);
    i_par_delay    = 12'($urandom);
    i_par_feedback = 8'($urandom);
    i_par_mix      = 8'($urandom);
  endtask

  task automatic do_reset();
    wait_ready(10000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_sample", int'($signed(o_sample)), 0);
`ifdef ECHO_CLEAR_EN
    check("rst_o_ready", int'(o_ready), 0);
`else
    check("rst_o_ready", int'(o_ready), 1);
`endif
    rst = 1'b1;
    m_wr = 0;
    m_wrapped = 1'b0;
    wait_ready(10000);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, cnt, s, fb, mix, want;

    // Impulse response, delay 3, fb 0.5, mix ~1
    vecs[0]  = '{16000, 3, 128, 255, 16000, 1'b1};
    vecs[1]  = '{0, 3, 128, 255, 0, 1'b0};
    vecs[2]  = '{0, 3, 128, 255, 0, 1'b0};
    vecs[3]  = '{0, 3, 128, 255, 15937, 1'b0};
    vecs[4]  = '{0, 3, 128, 255, 0, 1'b0};
    vecs[5]  = '{0, 3, 128, 255, 0, 1'b0};
    vecs[6]  = '{0, 3, 128, 255, 7968, 1'b0};
    vecs[7]  = '{0, 3, 128, 255, 0, 1'b0};
    vecs[8]  = '{0, 3, 128, 255, 0, 1'b0};
    vecs[9]  = '{0, 3, 128, 255, 3984, 1'b0};
    // Saturation of wet and feedback sums; delay 0 behaves as 1
    vecs[10] = '{30000, 1, 0, 255, 30000, 1'b1};
    vecs[11] = '{30000, 1, 0, 255, 32767, 1'b0};
    vecs[12] = '{-30000, 1, 0, 0, -30000, 1'b0};
    vecs[13] = '{-30000, 1, 0, 255, -32768, 1'b0};
    vecs[14] = '{-30000, 1, 255, 0, -30000, 1'b0};
    vecs[15] = '{0, 0, 0, 128, -16384, 1'b0};

    rst = 1'b0;
    do_reset();

    // Basic pass-through latency and o_ready busy window
    void'(model_step(1000, 4, 0, 0));
    drive(1000, 4, 0, 0, 1000);
    check("t1_ready_c1", int'(o_ready), 0);
    check("t1_valid_c1", int'(o_valid), 0);
    @(posedge clk); #1;
    check("t1_ready_c2", int'(o_ready), 0);
    check("t1_valid_c2", int'(o_valid), 0);
    @(posedge clk); #1;
    check("t1_ready_c3", int'(o_ready), 0);
    check("t1_valid_c3", int'(o_valid), 1);
    @(posedge clk); #1;
    check("t1_ready_c4", int'(o_ready), 1);
    check("t1_valid_c4", int'(o_valid), 0);

    // Second strobe while busy is dropped
    want = model_step(1234, 4, 0, 0);
    drive(1234, 4, 0, 0, want);
    i_valid = 1'b1;
    i_sample = 16'(-555);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_valid_at_T3", int'(o_valid), 1);
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (o_valid) nv++;
    end
    check("t5_extra_valids", nv, 0);

    // Table vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst_before) do_reset();
      void'(model_step(vecs[i].sample, vecs[i].delay, vecs[i].fb, vecs[i].mix));
      drive(vecs[i].sample, vecs[i].delay, vecs[i].fb, vecs[i].mix, vecs[i].exp_out);
    end

    // Reset while a sample sits in CALC
    do_reset();
    want = model_step(500, 1, 0, 0);
    drive(500, 1, 0, 0, want);
    wait_ready(100);
    i_valid = 1'b1;
    i_sample = 16'd7777;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("t6_o_valid", int'(o_valid), 0);
    check("t6_o_sample", int'($signed(o_sample)), 0);
    m_wr = 0;
    m_wrapped = 1'b0;
`ifdef ECHO_CLEAR_EN
    check("t6_o_ready", int'(o_ready), 0);
    cnt = 0;
    while (!o_ready && cnt < 10000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("t6_clear_cycles", cnt, depth);
`else
    check("t6_o_ready", int'(o_ready), 1);
`endif
    repeat (4) begin
      @(posedge clk); #1;
    end
    want = model_step(-2000, 1, 0, 255);
    drive(-2000, 1, 0, 255, want);
    want = model_step(0, 1, 0, 255);
    drive(0, 1, 0, 255, want);

    // Long run across the buffer wrap with maximum delay
    do_reset();
    for (int k = 0; k < depth + 5; k++) begin
      s   = int'($urandom_range(0, 8000)) - 4000;
      fb  = int'($urandom_range(0, 255));
      mix = int'($urandom_range(0, 255));
      want = model_step(s, depth - 1, fb, mix);
      drive(s, depth - 1, fb, mix, want);
    end
    wait_ready(100);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("o_sample_known", int'($isunknown(o_sample)), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
